// File: rtl/multicycle_cu_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// master = the sequencer, slave = the datapath side that consumes the controls.
interface multicycle_cu_if #(
  parameter int CNT_WIDTH = 32
) ();
  logic [5:0]           Opcode;
  logic                 Zero;
  logic                 MemReady;
  logic                 IorD;
  logic                 MemRead;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegDst;
  logic                 MemToReg;
  logic                 RegWrite;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ALUOp;
  logic [1:0]           PCSrc;
  logic                 ldPC;
  logic                 IllegalOp;
  logic                 InstrDone;
  logic [CNT_WIDTH-1:0] RetiredCount;

  modport master (
    input  Opcode, Zero, MemReady,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, ldPC, IllegalOp, InstrDone, RetiredCount
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, ldPC, IllegalOp, InstrDone, RetiredCount
  );
endinterface

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS sequencer: fetch/decode/execute/memory/writeback FSM driving
// every datapath select and enable, stalling on MemReady and counting retirements.
module multicycle_cu #(
  parameter logic [5:0] OP_RTYPE  = 6'b000000,
  parameter logic [5:0] OP_LW     = 6'b100011,
  parameter logic [5:0] OP_SW     = 6'b101011,
  parameter logic [5:0] OP_BEQ    = 6'b000100,
  parameter logic [5:0] OP_ADDI   = 6'b001000,
  parameter logic [5:0] OP_J      = 6'b000010,
  parameter int         CNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  multicycle_cu_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    I_EXEC    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11
  } state_t;

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] retired_cnt;

  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_write, pc_write_cond, ld_pc, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      retired_cnt <= '0;
    end else begin
      state <= state_nx;
      if (instr_done) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nx      = FETCH;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;

    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.MemReady;
        pc_write  = bus.MemReady;
        state_nx  = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        // ALUOut captures PC + (imm<<2) here so BRANCH can load it directly
        alu_src_b = 2'b11;
        case (bus.Opcode)
          OP_LW, OP_SW: state_nx = MEM_ADDR;
          OP_RTYPE:     state_nx = R_EXEC;
          OP_BEQ:       state_nx = BRANCH;
          OP_ADDI:      state_nx = I_EXEC;
          OP_J:         state_nx = JUMP;
          default: begin
            illegal_op = 1'b1;
            state_nx   = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.Opcode == OP_LW)      state_nx = MEM_READ;
        else if (bus.Opcode == OP_SW) state_nx = MEM_WRITE;
        else                          state_nx = FETCH;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_nx = bus.MemReady ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = bus.MemReady;
        state_nx   = bus.MemReady ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_nx  = R_WB;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nx  = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: state_nx = FETCH;
    endcase

    ld_pc = pc_write | (pc_write_cond & bus.Zero);

    // Reset masks the FETCH decode so no request escapes while rst is held
    if (rst) begin
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      ld_pc      = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign bus.IorD         = iord;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.IRWrite      = ir_write;
  assign bus.RegDst       = reg_dst;
  assign bus.MemToReg     = mem_to_reg;
  assign bus.RegWrite     = reg_write;
  assign bus.ALUSrcA      = alu_src_a;
  assign bus.ALUSrcB      = alu_src_b;
  assign bus.ALUOp        = alu_op;
  assign bus.PCSrc        = pc_src;
  assign bus.ldPC         = ld_pc;
  assign bus.IllegalOp    = illegal_op;
  assign bus.InstrDone    = instr_done;
  assign bus.RetiredCount = retired_cnt;

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
Main sequencing FSM for the team's multi-cycle MIPS datapath. It replaces the single-cycle CU/PCSrc glue. It walks each instruction through fetch, decode, execute, memory and writeback states, driving every datapath mux select and enable. It stalls in memory states until the shared instruction/data memory asserts MemReady, and it counts retired instructions.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch-equal
OP_ADDI, 6'b001000, add immediate
OP_J, 6'b000010, jump
CNT_WIDTH, 32, width of RetiredCount

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
Opcode  in  6  Instruction[31:26] from the instruction register
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes the current access this cycle
IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
RegDst  out  1  1 = rd, 0 = rt
MemToReg  out  1  1 = MDR to register file, 0 = ALUOut
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sext imm, 11 = sext imm<<2
ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded (to ALUCU)
PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ldPC  out  1  PC load = PCWriteUncond | (PCWriteCond & Zero)
IllegalOp  out  1  one-cycle pulse in DECODE on an unknown opcode
InstrDone  out  1  one-cycle pulse on the final cycle of each instruction
RetiredCount  out  CNT_WIDTH  number of completed instructions

Behaviour:
- 4-bit state register, updated only on posedge clk.
- rst forces state = FETCH and RetiredCount = 0 asynchronously.
- While rst is high, all enables are 0: MemRead, MemWrite, IRWrite, RegWrite, ldPC, InstrDone, IllegalOp. Selects are 0.
- Outputs are combinational from state, plus MemReady and Zero where noted. Signals not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite = ldPC = MemReady.
  - Stay in FETCH while !MemReady; go to DECODE when MemReady.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - RTYPE -> R_EXEC
  - BEQ -> BRANCH
  - ADDI -> I_EXEC
  - J -> JUMP
  - any other opcode -> FETCH, with IllegalOp=1 and InstrDone=0; the counter does not increment.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ if LW, MEM_WRITE if SW.
- MEM_READ: MemRead=1, IorD=1. Wait on MemReady, then go to MEM_WB.
- MEM_WB: RegDst=0, MemToReg=1, RegWrite=1, InstrDone=1. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until MemReady; InstrDone=MemReady. Go to FETCH on MemReady.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
- R_WB: RegDst=1, MemToReg=0, RegWrite=1, InstrDone=1. Go to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to I_WB.
- I_WB: RegDst=0, MemToReg=0, RegWrite=1, InstrDone=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, ldPC=Zero, InstrDone=1. Go to FETCH.
- JUMP: PCSrc=10, ldPC=1, InstrDone=1. Go to FETCH.
- Latency with MemReady tied high, in cycles:
  - R-type 4, ADDI 4, BEQ 3, J 3, SW 4, LW 5.
  - Each memory wait cycle adds 1.
- RetiredCount increments by 1 on each clock edge where InstrDone=1. It wraps to 0 past 2^CNT_WIDTH-1.
- MemReady is ignored in non-memory states.
- MemRead and MemWrite are never both 1.
- Opcode is sampled only in DECODE and MEM_ADDR; the IR is stable after FETCH.
- Reset asserted mid-instruction (for example during a MEM_WRITE stall) aborts immediately: MemWrite drops in the same cycle, and the counter clears.
- Unused state encodings -> FETCH on the next edge.

Test Plan:
- MemReady=1, Opcode=000000 -> state sequence FETCH, DECODE, R_EXEC, R_WB. In R_WB: RegWrite=1, RegDst=1, ALUOp=10. InstrDone pulses once; RetiredCount 0 -> 1.
- LW with MemReady low for 3 cycles in FETCH and 2 in MEM_READ -> 10 cycles total. IRWrite/ldPC high only on the MemReady cycle. MEM_WB has MemToReg=1, RegWrite=1.
- BEQ with Zero=1 -> ldPC=1, PCSrc=01 in BRANCH. Repeat with Zero=0 -> ldPC=0. Both retire (count +2).
- Opcode=6'b111111 -> IllegalOp pulses in DECODE. Next state is FETCH; RetiredCount unchanged; RegWrite/MemWrite never asserted.
- SW stalled with MemReady=0, then rst=1 asynchronously mid-cycle -> MemWrite=0 immediately, state=FETCH, RetiredCount=0. After release, fetch resumes.
- CNT_WIDTH=4: 16 J instructions -> RetiredCount returns to 0. JUMP state has PCSrc=10, ldPC=1.
